// File: rtl/lr_deserializer.sv
// Serial-to-parallel word collector with a single-entry valid/ready holding register.
// Define LR_DESER_PARITY_EN to expect a trailing even-parity bit after each word.
module lr_deserializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             msb_first,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow,
  output logic             busy,
  output logic             parity_err
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, COLLECT, PARITY} state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] sr, shifted, word;
  logic             order, order_q, last_data, complete, drain_ok;

  always_comb begin
    // bit order comes from the pin only on a word's first bit
    order     = (state == IDLE) ? msb_first : order_q;
    shifted   = order ? {sr[WIDTH-2:0], bit_in} : {bit_in, sr[WIDTH-1:1]};
    last_data = (count == CW'(WIDTH-1));
`ifdef LR_DESER_PARITY_EN
    complete  = bit_valid && (state == PARITY);
    word      = sr;
`else
    complete  = bit_valid && (state == COLLECT) && last_data;
    word      = shifted;
`endif
    drain_ok  = !out_valid || out_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      sr         <= '0;
      order_q    <= 1'b0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      overflow   <= 1'b0;
      busy       <= 1'b0;
`ifdef LR_DESER_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;

      if (bit_valid) begin
        case (state)
          IDLE: begin
            order_q <= msb_first;
            sr      <= shifted;
            count   <= CW'(1);
            state   <= COLLECT;
            busy    <= 1'b1;
          end
          COLLECT: begin
            sr <= shifted;
            if (last_data) begin
              count <= '0;
`ifdef LR_DESER_PARITY_EN
              state <= PARITY;
`else
              state <= IDLE;
              busy  <= 1'b0;
`endif
            end else begin
              count <= count + CW'(1);
            end
          end
`ifdef LR_DESER_PARITY_EN
          PARITY: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
`endif
          default: state <= IDLE;
        endcase
      end

      // a load here overrides the drain-clear above, so a same-edge refill has no bubble
      if (complete) begin
        if (drain_ok) begin
          out_data   <= word;
          out_valid  <= 1'b1;
`ifdef LR_DESER_PARITY_EN
          parity_err <= ^sr ^ bit_in;
`endif
        end else begin
          overflow <= 1'b1;
        end
      end
    end
  end

`ifndef LR_DESER_PARITY_EN
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_lr_deserializer.sv
// Scoreboard bench for lr_deserializer: a bit-queue reference model predicts accepted words,
// a negedge monitor checks the holding register against them.
module tb_lr_deserializer;
  localparam int W = 8;
`ifdef LR_DESER_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic         clk = 1'b0;
  logic         rst, bit_in, bit_valid, msb_first, out_ready;
  logic [W-1:0] out_data;
  logic         out_valid, overflow, busy, parity_err;

  lr_deserializer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .msb_first(msb_first),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .overflow(overflow), .busy(busy), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  int         n_vec = 0, n_bad = 0;
  logic [W:0] sb[$];      // {parity_err, word} accepted but not yet transferred
  bit         m_bits[$];  // bits of the word being collected
  bit         m_order, m_held, m_ovf;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Predicts the effect of the upcoming edge from the rules, word-at-a-time.
  task automatic model_step(input bit bv, input bit b, input bit msb, input bit rdy);
    bit         done = 1'b0;
    bit         pe   = 1'b0;
    logic [W-1:0] w  = '0;
    if (bv) begin
      if (m_bits.size() == 0) m_order = msb;
      m_bits.push_back(b);
      if (m_bits.size() == NB) begin
        for (int i = 0; i < W; i++)
          if (m_order) w[W-1-i] = m_bits[i];
          else         w[i]     = m_bits[i];
`ifdef LR_DESER_PARITY_EN
        for (int i = 0; i < NB; i++) pe = pe ^ m_bits[i];
`endif
        m_bits.delete();
        done = 1'b1;
      end
    end
    if (done) begin
      if (!m_held || rdy) begin
        sb.push_back({pe, w});
        m_held = 1'b1;
      end else begin
        m_ovf = 1'b1;
      end
    end else if (rdy) begin
      m_held = 1'b0;
    end
  endtask

  task automatic cyc(input bit bv, input bit b, input bit msb, input bit rdy);
    bit_valid = bv; bit_in = b; msb_first = msb; out_ready = rdy;
    model_step(bv, b, msb, rdy);
    @(posedge clk); #1;
    chk("out_valid", W'(out_valid), W'(m_held));
    chk("overflow",  W'(overflow),  W'(m_ovf));
    chk("busy",      W'(busy),      W'(m_bits.size() != 0));
  endtask

  task automatic do_reset();
    rst = 1'b1; bit_valid = 1'b1; bit_in = 1'($urandom);
    msb_first = 1'($urandom); out_ready = 1'($urandom);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0; bit_valid = 1'b0;
    sb.delete(); m_bits.delete(); m_held = 1'b0; m_ovf = 1'b0;
    chk("rst_out_data",   out_data,          '0);
    chk("rst_out_valid",  W'(out_valid),     '0);
    chk("rst_overflow",   W'(overflow),      '0);
    chk("rst_busy",       W'(busy),          '0);
    chk("rst_parity_err", W'(parity_err),    '0);
  endtask

  // Sends seq[W-1] first; the final edge (data or parity bit) uses rdy_last.
  task automatic send(input logic [W-1:0] seq, input bit msb, input bit toggle,
                      input bit rdy_body, input bit rdy_last, input bit bad_par);
    for (int i = 0; i < W; i++) begin
      bit last = (i == W-1) && (NB == W);
      bit m    = (i == 0 || !toggle) ? msb : 1'($urandom);
      cyc(1'b1, seq[W-1-i], m, last ? rdy_last : rdy_body);
    end
`ifdef LR_DESER_PARITY_EN
    cyc(1'b1, (^seq) ^ bad_par, 1'($urandom), rdy_last);
`else
    if (bad_par) chk("bad_par_unused", W'(bad_par), '0);
`endif
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL spurious_valid: got out_valid=1 data %h expected no pending word", out_data);
      end else begin
        chk("sb_out_data",   out_data,       sb[0][W-1:0]);
        chk("sb_parity_err", W'(parity_err), W'(sb[0][W]));
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    do_reset();

    send(8'hB2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("msb_word", out_data, 8'hB2);
    chk("msb_parity", W'(parity_err), '0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    send(8'hB2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("lsb_word", out_data, 8'h4D);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

    do_reset();
    send(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("bp_held_word", out_data, 8'hA5);
    chk("bp_overflow",  W'(overflow), 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    do_reset();
    send(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send(8'hC3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("drain_word",     out_data, 8'hC3);
    chk("drain_overflow", W'(overflow), '0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);

`ifdef LR_DESER_PARITY_EN
    do_reset();
    send(8'hB2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("par_ok_word", out_data, 8'hB2);
    chk("par_ok_flag", W'(parity_err), '0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    send(8'hB2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("par_bad_word", out_data, 8'hB2);
    chk("par_bad_flag", W'(parity_err), 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
`endif

    // reset mid-word, then a clean word must start from count 0
    repeat (3) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    do_reset();
    send(8'hB2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("post_rst_word", out_data, 8'hB2);

    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      cyc($urandom_range(0, 9) < 7, 1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0);
    end

    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("sb_drained", W'(sb.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
